// File: rtl/spi_pixel_pkg.sv
// Shared types and field positions for the SPI pixel sender and its optional RGB888 packer.
package spi_pixel_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int PIXEL_BITS = 16;
  localparam int R_MSB      = 15;
  localparam int G_MSB      = 11;
  localparam int B_MSB      = 7;
  localparam int NIBBLE     = 4;

  localparam int RGB_BITS   = 24;
  localparam int RGB_R_MSB  = 23;
  localparam int RGB_G_MSB  = 15;
  localparam int RGB_B_MSB  = 7;

endpackage

// File: rtl/spi_pixel_sender_rgb888_pack.sv
// Combinational 24-bit RGB888 to 16-bit RGB444+pad packer (top nibble of each channel).
module rgb888_pack
  import spi_pixel_pkg::*;
(
  input  logic [RGB_BITS-1:0]   i_rgb,
  output logic [PIXEL_BITS-1:0] o_word
);

  always_comb begin
    o_word                  = '0;
    o_word[R_MSB -: NIBBLE] = i_rgb[RGB_R_MSB -: NIBBLE];
    o_word[G_MSB -: NIBBLE] = i_rgb[RGB_G_MSB -: NIBBLE];
    o_word[B_MSB -: NIBBLE] = i_rgb[RGB_B_MSB -: NIBBLE];
  end

endmodule

// File: rtl/spi_pixel_sender.sv
// SPI-mode pixel word transmitter: MSB-first serialiser with inter-word gap and frame word counter.
// Optional macro SPI_PIXEL_SENDER_RGB888_EN widens i_pix_data to RGB888 and packs it at accept.
module spi_pixel_sender
  import spi_pixel_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int FRAME_WORDS = 2048
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
`ifdef SPI_PIXEL_SENDER_RGB888_EN
  input  logic [RGB_BITS-1:0]            i_pix_data,
`else
  input  logic [PIXEL_BITS-1:0]          i_pix_data,
`endif
  input  logic                           i_pix_valid,
  output logic                           o_pix_ready,
  output logic                           o_busy,
  output logic [$clog2(FRAME_WORDS)-1:0] o_word_count,
  output logic                           o_frame_done,
  output logic                           o_spi_clk,
  output logic                           o_spi_mosi
);

  localparam int WC_W    = $clog2(FRAME_WORDS);
  localparam int BIT_W   = $clog2(PIXEL_BITS);
  localparam int DIV_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_GAP_LAST  = DIV_W'(GAP_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_LAST       = WC_W'(FRAME_WORDS - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST     = BIT_W'(PIXEL_BITS - 1);

  logic [PIXEL_BITS-1:0] w_word;

`ifdef SPI_PIXEL_SENDER_RGB888_EN
  rgb888_pack u_pack (
    .i_rgb  (i_pix_data),
    .o_word (w_word)
  );
`else
  assign w_word = i_pix_data;
`endif

  state_t                r_state;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [PIXEL_BITS-1:0] r_shreg;
  logic                  r_pix_ready;
  logic                  r_busy;
  logic [WC_W-1:0]       r_word_count;
  logic                  r_frame_done;
  logic                  r_spi_clk;
  logic                  r_spi_mosi;

  // One counter serves both the spi_clk half-period and the inter-word gap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_div        <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_pix_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_word_count <= '0;
      r_frame_done <= 1'b0;
      r_spi_clk    <= 1'b0;
      r_spi_mosi   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_pix_valid && r_pix_ready) begin
            r_shreg     <= w_word;
            r_spi_mosi  <= w_word[PIXEL_BITS-1];
            r_bit_cnt   <= BIT_FIRST;
            r_div       <= '0;
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (r_div == DIV_HALF_LAST) begin
            r_spi_clk <= 1'b1;
            r_div     <= '0;
            r_state   <= SHIFT_HI;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (r_div == DIV_HALF_LAST) begin
            r_spi_clk <= 1'b0;
            r_div     <= '0;
            if (r_bit_cnt == '0) begin
              r_spi_mosi <= 1'b0;
              r_state    <= GAP;
            end else begin
              r_bit_cnt  <= r_bit_cnt - BIT_W'(1);
              r_spi_mosi <= r_shreg[r_bit_cnt - BIT_W'(1)];
              r_state    <= SHIFT_LO;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        GAP: begin
          if (r_div == DIV_GAP_LAST) begin
            r_div       <= '0;
            r_pix_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
            if (r_word_count == WC_LAST) begin
              r_word_count <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_word_count <= r_word_count + WC_W'(1);
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_pix_ready  = r_pix_ready;
  assign o_busy       = r_busy;
  assign o_word_count = r_word_count;
  assign o_frame_done = r_frame_done;
  assign o_spi_clk    = r_spi_clk;
  assign o_spi_mosi   = r_spi_mosi;

endmodule

// File: doc/spi_pixel_sender.md
Name: spi_pixel_sender

Overview:
- SPI-mode pixel stream transmitter that feeds the matrix panel controller's SPI word receiver from a host-side pixel source (soft CPU, test pattern generator or frame reader).
- Accepts 16-bit pixel words on a valid/ready handshake and serialises each one MSB-first on spi_clk/spi_mosi.
- Inserts an idle gap between words and counts words per frame, so the receiver's buffer flip happens on a frame boundary.
- Runs entirely in the system clk domain; spi_clk is a divided, registered output.

Parameters:
- CLK_DIV, 2, clk cycles per spi_clk half-period (>=1).
- GAP_CYCLES, 4, clk cycles spi_clk is held low after the final bit of each word (>=1).
- FRAME_WORDS, 2048, words per frame (64x32 panel, one buffer).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- pix_data  in  16  pixel word: [15:12] R, [11:8] G, [7:4] B, [3:0] reserved, transmitted as-is.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  sender can accept a word.
- busy  out  1  word in flight (any state except IDLE).
- word_count  out  $clog2(FRAME_WORDS)  words completed in the current frame.
- frame_done  out  1  one-cycle pulse when word FRAME_WORDS-1 completes.
- spi_clk  out  1  serial clock, idle low; receiver samples on the rising edge.
- spi_mosi  out  1  serial data; changes only while spi_clk is low.

Behaviour:
- Reset values: pix_ready=1, busy=0, word_count=0, frame_done=0, spi_clk=0, spi_mosi=0, state=IDLE, divider=0, bit_cnt=0.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, GAP.
- IDLE:
  - pix_ready=1.
  - On pix_valid&&pix_ready: shreg<=pix_data, spi_mosi<=pix_data[15], bit_cnt<=15, div<=0, go to SHIFT_LO.
  - pix_ready falls the next cycle.
- SHIFT_LO:
  - spi_clk=0 for CLK_DIV cycles.
  - On div==CLK_DIV-1: spi_clk<=1, div<=0, go to SHIFT_HI.
- SHIFT_HI:
  - spi_clk=1 for CLK_DIV cycles.
  - On div==CLK_DIV-1: spi_clk<=0.
  - If bit_cnt==0: spi_mosi<=0, go to GAP.
  - Else: bit_cnt--, spi_mosi<=shreg[bit_cnt-1], go to SHIFT_LO.
- GAP:
  - spi_clk=0 for GAP_CYCLES.
  - On the last cycle: word_count increments and the FSM returns to IDLE.
  - If word_count==FRAME_WORDS-1: word_count wraps to 0 and frame_done=1 for exactly that one cycle.
- Latency: from the accept edge to pix_ready high again is 2*16*CLK_DIV+GAP_CYCLES cycles (68 at defaults). No back-to-back words without a gap.
- Data stability: pix_data is sampled only at the accept edge; later changes are ignored. pix_valid held while pix_ready=0 has no effect.
- Simultaneous events: accept in the cycle pix_ready returns high is legal. frame_done and a new accept can coincide.
- Reset mid-word:
  - The word is abandoned and outputs return to reset values immediately (async).
  - The receiver's word framing is then undefined, so the system must reset both ends together.
- Width rule: word_count is exactly $clog2(FRAME_WORDS) bits. For FRAME_WORDS a power of two, the wrap equals natural overflow.

Optional Feature:
- Macro: SPI_PIXEL_SENDER_RGB888_EN.
- Defined:
  - pix_data becomes 24 bits: [23:16] R, [15:8] G, [7:0] B.
  - The word is packed at accept as {R[7:4],G[7:4],B[7:4],4'b0000}.
- Undefined:
  - pix_data is 16 bits and sent unmodified, reserved bits included.
- Timing is identical in both builds.

Decomposition:
- Package spi_pixel_pkg holds:
  - state enum (IDLE, SHIFT_LO, SHIFT_HI, GAP);
  - PIXEL_BITS=16;
  - field positions R_MSB=15, G_MSB=11, B_MSB=7, NIBBLE=4.
- Sub-module rgb888_pack (combinational 24->16 packer) is instantiated only under SPI_PIXEL_SENDER_RGB888_EN.
- FSM, divider and shift register stay in the top module.

Test Plan:
- Reset then idle 20 cycles -> spi_clk=0, spi_mosi=0, pix_ready=1, word_count=0.
- Accept 16'hA5F0, CLK_DIV=2 -> 16 rising spi_clk edges sample 1010_0101_1111_0000; spi_mosi never changes while spi_clk=1; pix_ready high again exactly 68 cycles after accept.
- pix_valid held high with words 16'h0001,16'h8000 -> two words sent, each followed by a 4-cycle low gap; word_count=2.
- Send FRAME_WORDS=4 (param override) words -> frame_done single-cycle pulse on 4th gap end; word_count reads 0 afterwards; 5th word gives word_count=1.
- Assert reset during bit 7 of a word -> spi_clk, spi_mosi and busy go to 0 asynchronously; after release next accepted word 16'h1234 transmits cleanly.
- With SPI_PIXEL_SENDER_RGB888_EN, accept 24'hFF8010 -> serialised word 16'hF810.
